// File: rtl/vfifo_dual_port_ram_be_pkg.sv
// Shared constants for the vfifo RAM family.
// Read-during-write mode encodings are reused by every vfifo RAM variant.
package vfifo_dual_port_ram_be_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

endpackage

// File: rtl/vfifo_dual_port_ram_be_if.sv
// One RAM access port: request fields driven by the user, read data and
// valid returned by the RAM.
interface vfifo_dual_port_ram_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  en;
    logic                  we;
    logic [NB-1:0]         be;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] d;
    logic [DATA_WIDTH-1:0] q;
    logic                  valid;

    modport master (output en, we, be, adr, d, input q, valid);
    modport slave  (input en, we, be, adr, d, output q, valid);

endinterface

// File: rtl/vfifo_dual_port_ram_be_rdport.sv
// Per-port read pipeline: read-during-write selection, optional output
// register and read-valid tracking.
module vfifo_dual_port_ram_be_rdport
    import vfifo_dual_port_ram_be_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_en,
    input  logic                             i_wr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]            i_d,
    input  logic [DATA_WIDTH-1:0]            i_old,
    output logic [DATA_WIDTH-1:0]            o_q,
    output logic                             o_valid
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] r_q1;
    logic                  r_v1;

    // Write-first view: this port's new lanes over the old word.
    always_comb begin
        w_merged = i_old;
        for (int i = 0; i < NB; i++) begin
            if (i_be[i]) w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = i_d[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    assign w_load  = i_en & ~((RDW_MODE == RDW_NO_CHANGE) & i_wr);
    assign w_rdata = ((RDW_MODE == RDW_WRITE_FIRST) & i_wr) ? w_merged : i_old;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_load;
            if (w_load) r_q1 <= w_rdata;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] r_q2;
        logic                  r_v2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q2 <= '0;
                r_v2 <= 1'b0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) r_q2 <= r_q1;
            end
        end

        assign o_q     = r_q2;
        assign o_valid = r_v2;
    end else begin : g_noreg
        assign o_q     = r_q1;
        assign o_valid = r_v1;
    end

endmodule

// File: rtl/vfifo_dual_port_ram_be.sv
// True dual-port byte-enable RAM: shared array, lane-wise write merge with
// port A priority on same-address lanes, and the registered collision flag.
module vfifo_dual_port_ram_be
    import vfifo_dual_port_ram_be_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    vfifo_dual_port_ram_be_if.slave    port_a,
    vfifo_dual_port_ram_be_if.slave    port_b,
    output logic                       collision
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("vfifo_dual_port_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RDW_MODE > RDW_NO_CHANGE) begin : g_bad_rdw
        $error("vfifo_dual_port_ram_be: RDW_MODE out of range");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_old_a;
    logic [DATA_WIDTH-1:0] w_old_b;
    logic                  w_wr_a;
    logic                  w_wr_b;
    logic                  r_collision;

    assign w_wr_a  = port_a.en & port_a.we & (|port_a.be);
    assign w_wr_b  = port_b.en & port_b.we & (|port_b.be);
    assign w_old_a = r_mem[port_a.adr];
    assign w_old_b = r_mem[port_b.adr];

    // B lanes are scheduled first so A's later assignment wins on a shared lane.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NB; i++) begin
                if (w_wr_b & port_b.be[i])
                    r_mem[port_b.adr][i*BYTE_WIDTH +: BYTE_WIDTH] <= port_b.d[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (w_wr_a & port_a.be[i])
                    r_mem[port_a.adr][i*BYTE_WIDTH +: BYTE_WIDTH] <= port_a.d[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_collision <= 1'b0;
        else        r_collision <= port_a.en & port_b.en & (port_a.adr == port_b.adr) & (w_wr_a | w_wr_b);
    end

    assign collision = r_collision;

    vfifo_dual_port_ram_be_rdport #(
        .DATA_WIDTH(DATA_WIDTH), .BYTE_WIDTH(BYTE_WIDTH), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)
    ) u_rdport_a (
        .clk(clk), .rst_n(rst_n), .i_en(port_a.en), .i_wr(w_wr_a), .i_be(port_a.be),
        .i_d(port_a.d), .i_old(w_old_a), .o_q(port_a.q), .o_valid(port_a.valid)
    );

    vfifo_dual_port_ram_be_rdport #(
        .DATA_WIDTH(DATA_WIDTH), .BYTE_WIDTH(BYTE_WIDTH), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)
    ) u_rdport_b (
        .clk(clk), .rst_n(rst_n), .i_en(port_b.en), .i_wr(w_wr_b), .i_be(port_b.be),
        .i_d(port_b.d), .i_old(w_old_b), .o_q(port_b.q), .o_valid(port_b.valid)
    );

endmodule
